// File: rtl/pio_in_irq_multi.sv
// Avalon-MM input PIO with per-bit sync/debounce, edge capture and a level/edge IRQ.
// Per-bit front end (sync + debounce) lives in pio_in_irq_bit, instantiated once per input.

module pio_in_irq_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) deb <= 1'b0;
        else          deb <= sync_out;
      end
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt;

      // deb follows only after DEBOUNCE_CYCLES+1 differing samples, so the
      // total input-to-deb latency is SYNC_STAGES+1+DEBOUNCE_CYCLES; the
      // counter clears on every match or update and so never exceeds its max.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
          deb <= 1'b0;
        end else if (sync_out == deb) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
          deb <= sync_out;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate
endmodule

module pio_in_irq_multi #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RISE_EN_RESET   = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] deb, deb_d, rise, fall;
  logic [WIDTH-1:0] irq_mask, edge_cap, rise_en, fall_en;
  logic             irq_mode;
  logic             wr_en;
  logic [WIDTH-1:0] wdata, w1c;
  logic [31:0]      rd_nxt;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      pio_in_irq_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (in_port[i]),
        .deb    (deb[i])
      );
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign w1c   = (wr_en && address == 3'd3) ? wdata : '0;
  assign rise  = deb & ~deb_d & rise_en;
  assign fall  = ~deb & deb_d & fall_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d    <= '0;
      irq_mode <= 1'b0;
      irq_mask <= '0;
      edge_cap <= '0;
      rise_en  <= RISE_EN_RESET;
      fall_en  <= '0;
    end else begin
      deb_d    <= deb;
      // A new edge on the same cycle as its clear wins, so no event is lost.
      edge_cap <= (edge_cap & ~w1c) | rise | fall;
      if (wr_en) begin
        case (address)
          3'd1:    irq_mode <= writedata[0];
          3'd2:    irq_mask <= wdata;
          3'd4:    rise_en  <= wdata;
          3'd5:    fall_en  <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (address)
      3'd0:    rd_nxt[WIDTH-1:0] = deb;
      3'd1:    rd_nxt[0]         = irq_mode;
      3'd2:    rd_nxt[WIDTH-1:0] = irq_mask;
      3'd3:    rd_nxt[WIDTH-1:0] = edge_cap;
      3'd4:    rd_nxt[WIDTH-1:0] = rise_en;
      3'd5:    rd_nxt[WIDTH-1:0] = fall_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_nxt;
  end

  assign irq = |(irq_mask & (irq_mode ? edge_cap : deb));
endmodule

// File: tb/tb_pio_in_irq_multi.sv
// Directed bench: u_dut uses defaults (no debounce), u_deb uses DEBOUNCE_CYCLES=4.
// Both share the Avalon bus; each has its own in_port.

module tb_pio_in_irq_multi;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port0 = '0, in_port1 = '0;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  pio_in_irq_multi u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port0),
    .readdata(rd0), .irq(irq0)
  );

  pio_in_irq_multi #(.DEBOUNCE_CYCLES(4)) u_deb (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port1),
    .readdata(rd1), .irq(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input bit sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a;
    tick(1);
    chk(tag, sel ? rd1 : rd0, exp);
  endtask

  initial begin
    logic [31:0] rst_exp [8];
    rst_exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0};

    // 1: reset state and register map
    tick(1);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_irq", 32'(irq0), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    for (int a = 0; a < 8; a++) rd(0, 3'(a), rst_exp[a], $sformatf("rst_a%0d", a));
    rd(1, 3'd4, 32'hFF, "deb_rst_rise_en");
    chk("rst_irq_run", 32'(irq0), 32'h0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(0, 3'd6, 32'h0, "reserved_rd");
    wr(3'd2, 32'hFFFF_FFFF);
    rd(0, 3'd2, 32'hFF, "mask_hi_bits");
    wr(3'd2, 32'h0);
    in_port0 = 8'hA5;
    tick(5);
    rd(0, 3'd0, 32'hA5, "data_a5");
    rd(0, 3'd3, 32'hA5, "cap_a5");
    in_port0 = 8'h00;
    tick(5);
    rd(0, 3'd0, 32'h00, "data_00");
    wr(3'd3, 32'hFF);
    rd(0, 3'd3, 32'h0, "cap_clr_all");

    // 2: edge mode, rising edge latency on bit 0
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h1);
    chk("e_irq_idle", 32'(irq0), 32'h0);
    address = 3'd3;
    in_port0[0] = 1'b1;
    tick(3);
    chk("e_irq_c3", 32'(irq0), 32'h0);
    tick(1);
    chk("e_irq_c4", 32'(irq0), 32'h1);
    tick(1);
    chk("e_cap_c4", rd0, 32'h1);
    wr(3'd3, 32'h1);
    chk("e_irq_clr", 32'(irq0), 32'h0);
    rd(0, 3'd3, 32'h0, "e_cap_clr");

    // 3: fall-only capture on bit 1, W1C of other bit leaves it
    wr(3'd5, 32'h2);
    wr(3'd4, 32'h0);
    in_port0[1] = 1'b1;
    tick(6);
    rd(0, 3'd3, 32'h0, "f_no_rise");
    in_port0[1] = 1'b0;
    tick(3);
    in_port0[1] = 1'b1;
    tick(6);
    rd(0, 3'd3, 32'h2, "f_cap");
    wr(3'd3, 32'h1);
    rd(0, 3'd3, 32'h2, "f_w1c_other");
    wr(3'd3, 32'h2);
    rd(0, 3'd3, 32'h0, "f_w1c_own");

    // 4: W1C on bit 2 coincides with its capture edge; set wins
    wr(3'd4, 32'h4);
    wr(3'd2, 32'h4);
    in_port0[2] = 1'b1;
    tick(3);
    wr(3'd3, 32'h4);
    chk("sc_irq", 32'(irq0), 32'h1);
    rd(0, 3'd3, 32'h4, "sc_cap");
    wr(3'd3, 32'h4);
    chk("sc_irq_clr", 32'(irq0), 32'h0);

    // 5: debounce on u_deb bit 0
    wr(3'd4, 32'h1);
    rd(1, 3'd3, 32'h0, "db_cap_pre");
    in_port1[0] = 1'b1;
    tick(3);
    in_port1[0] = 1'b0;
    tick(10);
    rd(1, 3'd0, 32'h0, "db_glitch_data");
    rd(1, 3'd3, 32'h0, "db_glitch_cap");
    address = 3'd0;
    in_port1[0] = 1'b1;
    tick(6);
    in_port1[0] = 1'b0;
    tick(1);
    chk("db_data_c6", rd1, 32'h0);
    tick(1);
    chk("db_data_c7", rd1, 32'h1);
    tick(20);
    rd(1, 3'd3, 32'h1, "db_one_rise");
    rd(1, 3'd0, 32'h0, "db_data_back");

    // 6: level mode on bit 7, then asynchronous reset mid-pulse
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h80);
    in_port0[7] = 1'b1;
    tick(4);
    chk("lvl_irq", 32'(irq0), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq0), 32'h0);
    chk("arst_rdata", rd0, 32'h0);
    in_port0 = '0;
    tick(2);
    reset_n = 1'b1;
    for (int a = 0; a < 6; a++) rd(0, 3'(a), rst_exp[a], $sformatf("post_rst_a%0d", a));
    rd(1, 3'd4, 32'hFF, "deb_post_rise_en");
    chk("post_rst_irq", 32'(irq0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
